// File: rtl/ks_cipher_streamer_if.sv
// Character stream from the cipher streamer to the LCD writer.
// The master presents one ASCII character per transfer; a transfer
// happens on a rising edge where char_valid and char_ready are both high.
interface ks_cipher_streamer_if;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_data;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/ks_cipher_streamer.sv
// ks_cipher_streamer: XORs the serial A5/1 keystream against a stored
// plaintext vector and streams the ciphertext out as ASCII hex characters.
// The full ciphertext is kept in a register, so the keystream never has to
// wait for the LCD side; draining starts as soon as the first nibble lands.
// Optional feature macro: KS_SPACE_SEP_EN inserts a space (0x20) after every
// 8th hex character (never after the final one).
module ks_cipher_streamer #(
    parameter int NIBBLES = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ks_bit,
    input  logic                 ks_valid,
    input  logic [4*NIBBLES-1:0] plaintext,
    ks_cipher_streamer_if.master chr,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);
    localparam int W  = 4 * NIBBLES;
    localparam int BW = $clog2(W + 1);
    localparam int RW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            ct_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [RW-1:0]           rd_nib_q;
    logic                    overrun_q;
    logic                    sep_pending;

    logic [BW-1:0]           bit_idx;
    logic [RW-1:0]           wr_nib;
    logic [RW-1:0]           rd_nib_inc;
    logic [RW-1:0]           nib_idx;
    logic [NIBBLES-1:0][3:0] ct_nib;
    logic [3:0]              cur_nib;
    logic [7:0]              hex_char;
    logic                    full;
    logic                    collect;
    logic                    xfer;
    logic                    last_xfer;

    // Bit k of a run is stored MSB-first, so nibble k sits at ct_nib[NIBBLES-1-k].
    assign full       = (bit_cnt_q == BW'(W));
    assign collect    = (state_q == RUN) && ks_valid && !full && !start;
    assign bit_idx    = BW'(W - 1) - bit_cnt_q;
    assign wr_nib     = RW'(bit_cnt_q >> 2);
    assign rd_nib_inc = rd_nib_q + RW'(1);
    assign nib_idx    = RW'(NIBBLES - 1) - rd_nib_q;
    assign ct_nib     = ct_q;
    assign cur_nib    = ct_nib[nib_idx];
    assign hex_char   = (cur_nib < 4'd10) ? (8'h30 + {4'h0, cur_nib})
                                          : (8'h37 + {4'h0, cur_nib});

    assign chr.char_valid = (state_q == RUN) && ((rd_nib_q < wr_nib) || sep_pending);
    assign xfer           = chr.char_valid && chr.char_ready;
    assign last_xfer      = xfer && !sep_pending && (rd_nib_inc == RW'(NIBBLES));

    // Output character: space while a separator is owed, else the hex digit; 0 when idle.
    always_comb begin
        chr.char_data = 8'h00;
        if (chr.char_valid)
            chr.char_data = sep_pending ? 8'h20 : hex_char;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start always (re)arms a run; the final hex transfer finishes it.
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = RUN;
        else if ((state_q == RUN) && last_xfer)
            state_d = DONE;
    end

    // Ciphertext capture, read pointer and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ct_q      <= '0;
            bit_cnt_q <= '0;
            rd_nib_q  <= '0;
            overrun_q <= 1'b0;
        end else if (start) begin
            ct_q      <= '0;
            bit_cnt_q <= '0;
            rd_nib_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (collect) begin
                ct_q[bit_idx] <= ks_bit ^ plaintext[bit_idx];
                bit_cnt_q     <= bit_cnt_q + BW'(1);
            end
            if ((state_q != IDLE) && ks_valid && full)
                overrun_q <= 1'b1;
            if (xfer && !sep_pending)
                rd_nib_q <= rd_nib_inc;
        end
    end

`ifdef KS_SPACE_SEP_EN
    logic sep_q;

    // Owe a space after every 8th hex character, except after the last nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sep_q <= 1'b0;
        else if (start)
            sep_q <= 1'b0;
        else if (xfer) begin
            if (sep_q)
                sep_q <= 1'b0;
            else
                sep_q <= (rd_nib_inc[2:0] == 3'd0) && (rd_nib_inc != RW'(NIBBLES));
        end
    end

    assign sep_pending = sep_q;
`else
    assign sep_pending = 1'b0;
`endif

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;
endmodule

// File: tb/tb_ks_cipher_streamer.sv
// Directed bench for ks_cipher_streamer: basic stream, XOR, backpressure,
// overrun, reset/restart. Expected characters come from hand-computed
// constants plus a small nibble-to-ASCII model of plaintext ^ keystream.
`timescale 1ns/1ps
module tb_ks_cipher_streamer;
    localparam int NIBBLES = 56;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ks_bit;
    logic         ks_valid;
    logic [W-1:0] plaintext;
    logic         busy;
    logic         done;
    logic         overrun;

    ks_cipher_streamer_if chr();

    ks_cipher_streamer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ks_bit    (ks_bit),
        .ks_valid  (ks_valid),
        .plaintext (plaintext),
        .chr       (chr.master),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    int         first_xfer;
    int         last_xfer;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       prev_vld;
    logic       prev_rdy;
    logic [7:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected character stream for a given ciphertext.
    function automatic void build_exp(input logic [W-1:0] ct);
        exp_q.delete();
        for (int k = 0; k < NIBBLES; k++) begin
            logic [3:0] n;
            n = ct[W-1-4*k -: 4];
            exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
`ifdef KS_SPACE_SEP_EN
            if (((k + 1) % 8 == 0) && (k + 1 < NIBBLES))
                exp_q.push_back(8'h20);
`endif
        end
    endfunction

    // One clock: drive inputs, log any transfer, check stall stability.
    task automatic cycle(input logic kv, input logic kb, input logic cr);
        ks_valid       = kv;
        ks_bit         = kb;
        chr.char_ready = cr;
        if (prev_vld && !prev_rdy) begin
            chk("stall_valid", chr.char_valid, 1);
            chk("stall_data", chr.char_data, prev_data);
        end
        if (chr.char_valid && cr) begin
            got.push_back(chr.char_data);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        prev_vld  = chr.char_valid;
        prev_rdy  = cr;
        prev_data = chr.char_data;
        @(posedge clk); #1;
        cyc++;
    endtask

    // Start pulse carries a keystream bit that must be discarded.
    task automatic pulse_start();
        start          = 1'b1;
        ks_valid       = 1'b1;
        ks_bit         = 1'b1;
        chr.char_ready = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        ks_valid   = 1'b0;
        got.delete();
        first_xfer = -1;
        last_xfer  = -1;
        prev_vld   = 1'b0;
        cyc        = 0;
    endtask

    task automatic do_run(input string tag, input logic [W-1:0] pt, input logic [W-1:0] ks,
                          input bit stall, input bit extra);
        plaintext = pt;
        pulse_start();
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_ovr_start"}, overrun, 0);
        for (int k = 0; k < W; k++) cycle(1'b1, ks[W-1-k], !stall);
        if (extra) begin
            cycle(1'b1, 1'b1, !stall);
            chk({tag, "_overrun_set"}, overrun, 1);
        end
        for (int k = 0; k < 300 && !done; k++) cycle(1'b0, 1'b0, 1'b1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_done_lat"}, cyc, last_xfer + 1);
        chk({tag, "_first_xfer"}, first_xfer, stall ? (W + (extra ? 1 : 0)) : 4);
        if (stall) chk({tag, "_back2back"}, last_xfer - first_xfer, got.size() - 1);
        build_exp(pt ^ ks);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_char%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        logic [W-1:0] v;

        reset = 1'b1; start = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0;
        plaintext = '0; chr.char_ready = 1'b0;
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_data = 8'h00; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", chr.char_valid, 0);
        chk("rst_data", chr.char_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        chk("idle_overrun", overrun, 0);
        chk("idle_valid", chr.char_valid, 0);
        chk("idle_busy", busy, 0);

        // Basic stream: A3 then zeros.
        v = '0;
        v[W-1 -: 8] = 8'hA3;
        do_run("basic", '0, v, 1'b0, 1'b0);
        chk("basic_c0", got[0], 8'h41);
        chk("basic_c1", got[1], 8'h33);
`ifdef KS_SPACE_SEP_EN
        chk("sep_total", got.size(), 62);
        for (int i = 1; i <= 6; i++) chk($sformatf("sep_pos%0d", 9 * i), got[9*i-1], 8'h20);
        chk("sep_last", got[61], 8'h30);
`else
        chk("basic_total", got.size(), 56);
        chk("basic_last", got[55], 8'h30);
`endif

        // XOR check: all-ones plaintext, zero keystream -> 'F'.
        do_run("xor", {W{1'b1}}, '0, 1'b0, 1'b0);
        chk("xor_c0", got[0], 8'h46);
        chk("xor_last", got[got.size()-1], 8'h46);

        // Backpressure for the whole collection.
        do_run("bp", {7{32'h89AB_CDEF}}, {7{32'h1357_9BDF}}, 1'b1, 1'b0);
        chk("bp_c0", got[0], 8'h39);
        chk("bp_c1", got[1], 8'h41);

        // Overrun: one extra bit after the full vector.
        v = '0;
        v[W-1 -: 8] = 8'hA3;
        do_run("ovr", '0, v, 1'b1, 1'b1);
        chk("ovr_c0", got[0], 8'h41);
        chk("ovr_sticky", overrun, 1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("ovr_in_done", overrun, 1);
        chk("ovr_done_held", done, 1);
        pulse_start();
        chk("ovr_cleared", overrun, 0);
        chk("ovr_restart_busy", busy, 1);

        // Reset mid-run with characters waiting.
        plaintext = '0;
        pulse_start();
        for (int k = 0; k < 100; k++) cycle(1'b1, k[0], 1'b0);
        chk("pre_rst_valid", chr.char_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", chr.char_valid, 0);
        chk("mid_rst_data", chr.char_data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_overrun", overrun, 0);
        @(posedge clk); #1;
        reset    = 1'b0;
        prev_vld = 1'b0;
        cycle(1'b1, 1'b1, 1'b1);
        chk("post_rst_valid", chr.char_valid, 0);
        chk("post_rst_busy", busy, 0);

        // Restart after 50 bits, then a complete run.
        pulse_start();
        for (int k = 0; k < 50; k++) cycle(1'b1, 1'b1, 1'b1);
        do_run("restart", {7{32'hDEAD_BEEF}}, {7{32'h0F1E_2D3C}}, 1'b0, 1'b0);
        chk("restart_c0", got[0], 8'h44);
        chk("restart_c1", got[1], 8'h31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ks_cipher_streamer.md
# ks_cipher_streamer

Downstream stage of the A5/1 keystream generator. It takes the serial keystream bits (`a51out` qualified by `KeyStreamReady & ~KeyStreamDepleted`) and XORs them on the fly against the stored plaintext vector. It buffers the resulting ciphertext nibbles and streams them out as ASCII hex characters to the LCD writer over a valid/ready handshake. Draining starts as soon as the first nibble is complete, so the slow LCD never stalls the free-running keystream.

## Interface
- `NIBBLES`, 56, number of ciphertext nibbles; data width W = 4*NIBBLES bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  single-cycle pulse; clears counters and arms a new run.
- `ks_bit`  in  1  keystream bit.
- `ks_valid`  in  1  `ks_bit` is valid this cycle; cannot be stalled.
- `plaintext`  in  W  plaintext vector; held stable for the whole run.
- `char_ready`  in  1  LCD writer accepts `char_data` this cycle.
- `char_valid`  out  1  `char_data` holds a character for transfer.
- `char_data`  out  8  ASCII character.
- `busy`  out  1  state is RUN.
- `done`  out  1  all characters transferred; held until `start` or `reset`.
- `overrun`  out  1  sticky; `ks_valid` was seen after W bits had been collected.

## Operation
- **States:** IDLE, RUN, DONE.
  - Reset → IDLE.
  - `start` in any state → RUN, clearing `bit_cnt`, `rd_nib`, the ciphertext register, `overrun` and the separator flag.
- **Collect (RUN):**
  - On `ks_valid` with `bit_cnt < W`: the ciphertext bit `ks_bit ^ plaintext[W-1-bit_cnt]` is stored at position `W-1-bit_cnt`, then `bit_cnt++`.
  - Bit k of the run lands in nibble k/4. The first-arriving bit of each nibble is the nibble's MSB.
- **Overrun:** `ks_valid` while `bit_cnt == W` (in RUN or DONE) sets `overrun`. The stored ciphertext is unchanged.
  - `ks_valid` in IDLE is ignored and does not set `overrun`.
- **Completed nibbles:** `wr_nib = bit_cnt / 4`.
- **Emit:**
  - `char_valid = (state == RUN) && (rd_nib < wr_nib || sep_pending)`.
  - `char_data` is the hex ASCII of nibble `rd_nib`: 0–9 map to 0x30–0x39, A–F map to 0x41–0x46.
  - A transfer occurs when `char_valid && char_ready`; it advances `rd_nib`.
  - `char_data` is stable while `char_valid` is high and `char_ready` is low.
- **Completion:** the transfer of the last nibble (`rd_nib` becomes NIBBLES) with no separator pending moves the FSM to DONE and sets `done`.
- **Simultaneous events:**
  - A nibble completing in the same cycle as a transfer is legal; both counters update.
  - `start` coincident with `ks_valid` restarts the run; that bit is discarded.
- **Reset mid-operation:** all state is lost immediately; no partial character is emitted afterwards.
- **Output values on reset:** `char_valid`=0, `char_data`=0x00, `busy`=0, `done`=0, `overrun`=0.

## Timing
- A nibble completed at clock edge t has `char_valid` high from edge t onward (visible in cycle t+1).
- Throughput is 1 character per cycle while data is available and `char_ready` is high.
- Keystream input accepts 1 bit per cycle with no backpressure. Storing the full W bits guarantees no loss regardless of `char_ready`.
- `done` rises on the edge that performs the final transfer.
- `busy` falls on that same edge.

## Configuration
- **`KS_SPACE_SEP_EN` defined:**
  - After the 8th, 16th, … hex character, a space (0x20) is emitted before the next nibble, using the `sep_pending` flag.
  - No space follows the final nibble.
  - Total characters = NIBBLES + (NIBBLES-1)/8, i.e. 62 for NIBBLES = 56.
- **`KS_SPACE_SEP_EN` undefined:**
  - Only hex characters are emitted; total = NIBBLES.
  - `sep_pending` is tied to 0.

## Test plan
- **Basic stream:** `plaintext`=0, `start`, then `ks_bit` sequence 1,0,1,0,0,0,1,1 followed by 216 zeros, `char_ready`=1 → `char_data` 0x41, 0x33, then 54×0x30.
  - `done`=1 after the 56th transfer.
  - `busy` is low one cycle after the final transfer.
- **XOR check:** `plaintext`=all ones, keystream all zeros → 56×0x46 ('F').
- **Backpressure:** `char_ready`=0 for the entire 224-bit collection, then 1 → all 56 characters emitted in order on consecutive cycles.
  - `char_data` must not change while stalled.
- **Overrun:** one extra `ks_valid` after 224 bits → `overrun`=1 and remains set.
  - The remaining emitted characters are unchanged.
  - A following `start` clears `overrun`.
- **Reset/restart:** assert `reset` after 100 bits → all outputs 0 in the same cycle, state IDLE.
  - `start` after 50 bits → counters restart; the next full run emits 56 correct characters.
- **With `KS_SPACE_SEP_EN`:** run the basic-stream stimulus → 62 characters total.
  - Characters 9, 18, 27, 36, 45 and 54 (1-based) are 0x20.
  - The final character is 0x30.
